// File: rtl/display_arbiter_if.sv
// Handshake bundle between the two display sources and display_arbiter.
// The master side is the pair of value sources; the slave side is the arbiter,
// which returns the grants, the selected display word and the blank flag.
interface display_arbiter_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        gnt_a;
    logic        gnt_b;
    logic [15:0] digito;
    logic        blank;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  gnt_a, gnt_b, digito, blank
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output gnt_a, gnt_b, digito, blank
    );
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin sharing of one four-digit multiplexed display
// between source A (keypad entry) and source B (computed result). A granted
// source keeps the display for at least HOLD_CYCLES cycles; its value is
// refreshed live while it keeps requesting and frozen once it lets go.
// Optional feature macro DISP_ARB_BLINK_EN: blinks a stale frozen value by
// toggling blank every BLINK_CYCLES stale cycles.
module display_arbiter #(
    parameter int HOLD_CYCLES  = 1000,
    parameter int BLINK_CYCLES = 500
) (
    input  logic              clk,
    input  logic              rst,
    display_arbiter_if.slave  bus
);

    localparam int            CW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

    // Reject illegal parameterisations at elaboration time.
    if (HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("display_arbiter: HOLD_CYCLES and BLINK_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW_A = 2'd1,
        ST_SHOW_B = 2'd2
    } state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    state_e          state_q, state_d;
    src_e            last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [15:0]     digito_q, digito_d;
    logic            gnt_a_q, gnt_a_d;
    logic            gnt_b_q, gnt_b_d;
    logic            blank_q, blank_d;
    logic            expired;

`ifdef DISP_ARB_BLINK_EN
    localparam int            BW       = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            phase_q, phase_d;
    logic            stale;
`endif

    assign expired = (cnt_q == CNT_MAX);

    // Next owner, round-robin pointer, hold counter and display word.
    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        digito_d = digito_q;

        case (state_q)
            ST_IDLE: begin
                // Sole requester wins; on a tie the source not served last wins.
                if (bus.req_a && (!bus.req_b || last_q == SRC_B)) begin
                    state_d  = ST_SHOW_A;
                    last_d   = SRC_A;
                    cnt_d    = '0;
                    digito_d = bus.data_a;
                end else if (bus.req_b) begin
                    state_d  = ST_SHOW_B;
                    last_d   = SRC_B;
                    cnt_d    = '0;
                    digito_d = bus.data_b;
                end
            end

            ST_SHOW_A: begin
                if (expired && bus.req_b) begin
                    state_d  = ST_SHOW_B;
                    last_d   = SRC_B;
                    cnt_d    = '0;
                    digito_d = bus.data_b;
                end else begin
                    if (!expired) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (bus.req_a) begin
                        digito_d = bus.data_a;
                    end
                end
            end

            ST_SHOW_B: begin
                if (expired && bus.req_a) begin
                    state_d  = ST_SHOW_A;
                    last_d   = SRC_A;
                    cnt_d    = '0;
                    digito_d = bus.data_a;
                end else begin
                    if (!expired) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (bus.req_b) begin
                        digito_d = bus.data_b;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant and blank outputs, computed from the next state so they register cleanly.
    always_comb begin
        gnt_a_d = (state_d == ST_SHOW_A);
        gnt_b_d = (state_d == ST_SHOW_B);
`ifdef DISP_ARB_BLINK_EN
        stale = ((state_q == ST_SHOW_A) && expired && !bus.req_a) ||
                ((state_q == ST_SHOW_B) && expired && !bus.req_b);
        bcnt_d  = '0;
        phase_d = 1'b0;
        // Blink only while the owner stays put with a stale value; a hand-over clears it.
        if (stale && (state_d == state_q)) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
                phase_d = phase_q;
            end
        end
        blank_d = (state_d == ST_IDLE) || phase_d;
`else
        blank_d = (state_d == ST_IDLE);
`endif
    end

    // State and registered outputs, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= SRC_B;
            cnt_q    <= '0;
            digito_q <= 16'h0000;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            blank_q  <= 1'b1;
`ifdef DISP_ARB_BLINK_EN
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            digito_q <= digito_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            blank_q  <= blank_d;
`ifdef DISP_ARB_BLINK_EN
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
`endif
        end
    end

    assign bus.gnt_a  = gnt_a_q;
    assign bus.gnt_b  = gnt_b_q;
    assign bus.digito = digito_q;
    assign bus.blank  = blank_q;

endmodule
